pwm_duty_meter: RTL and testbench

Measures an incoming PWM waveform and reports its period, high time and 8-bit duty cycle, measured in system clock cycles. It is the receive-side counterpart of the board's PWM LED drivers. It closes the loop on generated PWM, or reads an external PWM source such as a fan tachometer or servo line, on the same single-clock CPLD design. A stuck-level detector reports 0 % or 100 % when edges stop arriving.

---
 rtl/pwm_duty_meter.sv | 148 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - PWM period, high-time and duty meter with stuck-level detection
// Counts clk cycles between rising edges of pwm_in and divides high time by period.
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535,
  parameter int DUTY_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam int               IT_W    = $clog2(DUTY_W + 1);
  localparam logic [IT_W-1:0]  IT_LAST = IT_W'(DUTY_W - 1);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t state, state_nx;

  logic              s_meta, s, s_d;
  logic              rise, busy, capture, last_iter, tmo_hit;
  logic              armed;
  logic [CNT_W-1:0]  per_ctr, hi_ctr;
  logic [CNT_W-1:0]  div_p, div_h, rem;
  logic [DUTY_W-1:0] quo;
  logic [IT_W-1:0]   it_cnt;

  logic [CNT_W:0]    rem_sh, rem_nx;
  logic              q_bit;
  logic [DUTY_W-1:0] quo_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= pwm_in;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  assign rise      = s & ~s_d;
  assign busy      = (state == S_DIV);
  assign capture   = rise & armed & ~busy;
  assign last_iter = busy && (it_cnt == IT_LAST);
  // >= rather than == so a timeout deferred by a busy divider still fires when per_ctr has moved past TIMEOUT
  assign tmo_hit   = ~rise & ~busy & ~stuck & (per_ctr >= TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_ctr <= '0;
      hi_ctr  <= '0;
    end else if (rise) begin
      per_ctr <= CNT_W'(1);
      hi_ctr  <= CNT_W'(1);
    end else begin
      if (per_ctr != CNT_MAX) per_ctr <= per_ctr + CNT_W'(1);
      if (s && hi_ctr != CNT_MAX) hi_ctr <= hi_ctr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (rise) begin
      armed <= 1'b1;
    end else if (tmo_hit) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (capture)   state_nx = S_DIV;
      S_DIV:   if (last_iter) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Restoring division of H * 2^DUTY_W by P; remainder stays below P so CNT_W bits hold it
  always_comb begin
    rem_sh = {rem, 1'b0};
    q_bit  = (rem_sh >= {1'b0, div_p});
    rem_nx = q_bit ? (rem_sh - {1'b0, div_p}) : rem_sh;
    quo_nx = DUTY_W'({quo, q_bit});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_p  <= '0;
      div_h  <= '0;
      rem    <= '0;
      quo    <= '0;
      it_cnt <= '0;
    end else if (capture) begin
      div_p  <= per_ctr;
      div_h  <= hi_ctr;
      rem    <= hi_ctr;
      quo    <= '0;
      it_cnt <= '0;
    end else if (busy) begin
      rem    <= rem_nx[CNT_W-1:0];
      quo    <= quo_nx;
      it_cnt <= it_cnt + IT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (last_iter) begin
        period_cnt <= div_p;
        high_cnt   <= div_h;
        duty       <= quo_nx;
        valid      <= 1'b1;
        stuck      <= 1'b0;
      end else if (tmo_hit) begin
        period_cnt <= '0;
        high_cnt   <= '0;
        duty       <= s ? '1 : '0;
        valid      <= 1'b1;
        stuck      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - self-checking bench for pwm_duty_meter against an edge-history model
module tb_pwm_duty_meter;

  localparam int CNT_W  = 16;
  localparam int DUTY_W = 8;
  localparam int TMO    = 300;
  localparam int NMAX   = 65536;
  localparam int SATV   = 65535;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pwm_in = 1'b0;
  logic [CNT_W-1:0]  period_cnt, high_cnt;
  logic [DUTY_W-1:0] duty;
  logic              valid, stuck;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO), .DUTY_W(DUTY_W)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .duty(duty),
    .valid(valid), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: pin[k] is pwm_in as sampled at edge k; s in cycle c is pin[c-1]
  bit pin [NMAX];
  int k = 0;
  int last_rise = 0, busy_until = -100, res_cycle = 0;
  bit armed = 0, m_stuck = 0, pending = 0;
  int r_per, r_hi, r_duty;
  int e_per = 0, e_hi = 0, e_duty = 0;
  bit e_valid = 0;

  int n_valid = 0, n_stuck_valid = 0, last_vc = 0, prev_vc = 0;
  int snap_per = 0, snap_hi = 0, snap_duty = 0, snap_stuck = 0;
  int last_rise_drive = 0;

  function automatic int sat(int x);
    return (x > SATV) ? SATV : x;
  endfunction

  function automatic bit s_at(int c);
    if (c < 1 || c > NMAX) return 1'b0;
    return pin[c-1];
  endfunction

  task automatic model_step();
    int c, p, h;
    bit rise;
    k++;
    pin[k] = pwm_in;
    e_valid = 1'b0;
    if (!rst_n) begin
      pin[k] = 1'b0;
      pin[k-1] = 1'b0;
      last_rise = k;
      armed = 0; m_stuck = 0; pending = 0; busy_until = -100;
      e_per = 0; e_hi = 0; e_duty = 0;
    end else begin
      c = k - 1;
      rise = s_at(c) && !s_at(c-1);
      if (rise) begin
        if (armed && c > busy_until) begin
          p = sat(c - last_rise);
          h = 0;
          for (int j = last_rise; j < c; j++) h += int'(s_at(j));
          h = sat(h);
          r_per = p; r_hi = h; r_duty = (h * 256) / p;
          pending = 1; res_cycle = c + 9; busy_until = c + 8;
        end
        armed = 1;
        last_rise = c;
      end else if (sat(c - last_rise) >= TMO && c > busy_until && !m_stuck) begin
        m_stuck = 1; e_valid = 1; e_per = 0; e_hi = 0;
        e_duty = s_at(c) ? 255 : 0;
        armed = 0;
      end
      if (pending && res_cycle == k) begin
        e_per = r_per; e_hi = r_hi; e_duty = r_duty;
        e_valid = 1; m_stuck = 0; pending = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    int xp, xh, xd;
    bit xv, xs;
    @(negedge clk);
    if (k >= 1) begin
      xp = rst_n ? e_per : 0;
      xh = rst_n ? e_hi : 0;
      xd = rst_n ? e_duty : 0;
      xv = rst_n ? e_valid : 1'b0;
      xs = rst_n ? m_stuck : 1'b0;
      checks++;
      if (period_cnt !== CNT_W'(xp) || high_cnt !== CNT_W'(xh) || duty !== DUTY_W'(xd) ||
          valid !== xv || stuck !== xs) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs cycle=%0d actual per=%0d hi=%0d duty=%0d valid=%0b stuck=%0b required per=%0d hi=%0d duty=%0d valid=%0b stuck=%0b",
                   k, period_cnt, high_cnt, duty, valid, stuck, xp, xh, xd, xv, xs);
      end
    end
    if (valid === 1'b1) begin
      n_valid++;
      prev_vc = last_vc;
      last_vc = k;
      if (stuck === 1'b1) n_stuck_valid++;
      snap_per = int'(period_cnt); snap_hi = int'(high_cnt);
      snap_duty = int'(duty); snap_stuck = int'(stuck);
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wave(int per, int hi, int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      last_rise_drive = k;
      tick(hi);
      pwm_in = 1'b0;
      tick(per - hi);
    end
  endtask

  initial begin
    int nv, nsv, per, hi;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    tick(5);
    check("reset_period", int'(period_cnt), 0);
    check("reset_high", int'(high_cnt), 0);
    check("reset_duty", int'(duty), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_stuck", int'(stuck), 0);
    rst_n = 1'b1;
    tick(3);

    wave(100, 25, 5);
    check("d25_valid_count", n_valid, 4);
    check("d25_period", snap_per, 100);
    check("d25_high", snap_hi, 25);
    check("d25_duty", snap_duty, 64);
    check("d25_stuck", snap_stuck, 0);
    check("d25_latency", last_vc - last_rise_drive, DUTY_W + 3);

    wave(100, 75, 3);
    check("d75_high", snap_hi, 75);
    check("d75_duty", snap_duty, 192);
    wave(50, 1, 3);
    check("d1of50_high", snap_hi, 1);
    check("d1of50_duty", snap_duty, 5);

    wave(100, 25, 3);
    nv = n_valid; nsv = n_stuck_valid;
    pwm_in = 1'b1;
    tick(TMO + 100);
    check("stuckhi_valids", n_valid - nv, 2);
    check("stuckhi_stuck_valids", n_stuck_valid - nsv, 1);
    check("stuckhi_duty", snap_duty, 255);
    check("stuckhi_period", snap_per, 0);
    check("stuckhi_stuck", snap_stuck, 1);
    pwm_in = 1'b0;
    tick(10);

    nv = n_valid;
    wave(100, 25, 3);
    check("rearm_valids", n_valid - nv, 2);
    nv = n_valid; nsv = n_stuck_valid;
    tick(TMO + 100);
    check("stucklo_valids", n_valid - nv, 1);
    check("stucklo_duty", snap_duty, 0);
    check("stucklo_stuck", snap_stuck, 1);

    nv = n_valid;
    wave(100, 25, 1);
    check("recover_first_rise", n_valid - nv, 0);
    wave(100, 25, 1);
    check("recover_second_rise", n_valid - nv, 1);
    check("recover_stuck", snap_stuck, 0);
    check("recover_period", snap_per, 100);

    wave(6, 3, 10);
    tick(12);
    check("fast_period", snap_per, 6);
    check("fast_high", snap_hi, 3);
    check("fast_duty", snap_duty, 128);
    check("fast_spacing", last_vc - prev_vc, 12);

    wave(100, 25, 2);
    nv = n_valid;
    pwm_in = 1'b1;
    tick(5);
    rst_n = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("rstmid_no_valid", n_valid - nv, 0);
    check("rstmid_period", int'(period_cnt), 0);
    check("rstmid_high", int'(high_cnt), 0);
    check("rstmid_duty", int'(duty), 0);
    check("rstmid_stuck", int'(stuck), 0);
    wave(100, 25, 1);
    check("rstmid_first_rise", n_valid - nv, 0);
    wave(100, 25, 1);
    check("rstmid_second_rise", n_valid - nv, 1);
    check("rstmid_duty_after", snap_duty, 64);

    for (int i = 0; i < 25; i++) begin
      per = int'($urandom_range(150, 3));
      hi  = int'($urandom_range(per - 1, 1));
      wave(per, hi, 1);
    end
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
